programmer_link: RTL and testbench
==================================

# programmer_link

Host-side front end of the programming path. Receives an asynchronous 8N1 serial stream, decodes a small framed protocol, and drives the programmer's control inputs: programming-mode reset, command strobe, data strobe and the shared 8-bit data bus. It sits directly upstream of the programmer block, which consumes `PROGRAMMER_RESET`, `PROGRAMMER_InputData`, `PROGRAMMER_PCK` and `PROGRAMMER_SCK`.

## Interface
- `CLKS_PER_BIT`, 16, CLK cycles per serial bit; minimum 4.
- `CLK` input 1: sole clock; all logic on rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `RXD` input 1: serial line; idle high; asynchronous to CLK.
- `PROGRAMMER_RESET` output 1: programming mode active; holds the cores in reset.
- `PROGRAMMER_InputData` output 8: command or data byte to the programmer.
- `PROGRAMMER_PCK` output 1: one-cycle command strobe.
- `PROGRAMMER_SCK` output 1: one-cycle data strobe.
- `LINK_ERROR` output 1: sticky protocol or framing error flag.

## Operation
**Receiver**
- `RXD` passes through a 2-flop synchronizer.
- States: RX_IDLE, RX_START, RX_DATA, RX_STOP.
- RX_IDLE: a synchronized falling edge loads a bit counter with `CLKS_PER_BIT/2` and enters RX_START.
- RX_START: at mid-start, low goes to RX_DATA; high is a glitch and returns to RX_IDLE with no error.
- RX_DATA: samples 8 bits LSB-first, one every `CLKS_PER_BIT` cycles.
- RX_STOP: samples the stop bit. High produces a 1-cycle internal `rx_valid` with the byte. Low raises a framing error and discards the byte.
- Both stop outcomes return to RX_IDLE.

**Decoder** (states DEC_HDR, DEC_DATA)
- 0xA5: sets `PROGRAMMER_RESET`=1 and clears `LINK_ERROR`.
- 0x5A: sets `PROGRAMMER_RESET`=0.
- 0xC0–0xC7: command. If `PROGRAMMER_RESET`=1, drives `PROGRAMMER_InputData`={5'b0, byte[2:0]} and pulses `PCK`. Otherwise it is dropped and sets `LINK_ERROR`.
- 0xD0: if `PROGRAMMER_RESET`=1, goes to DEC_DATA. Otherwise it is dropped and sets `LINK_ERROR`.
- DEC_DATA: the next byte is taken verbatim, including 0xA5, 0x5A and 0xCx. It drives `PROGRAMMER_InputData` and pulses `SCK`, then returns to DEC_HDR.
- Any other header byte sets `LINK_ERROR` and stays in DEC_HDR.
- A framing error in either state sets `LINK_ERROR` and forces DEC_HDR; a pending data byte is abandoned.
- `PROGRAMMER_InputData` holds its last value between strobes.
- `PCK` and `SCK` are never high together.
- `LINK_ERROR` stays set until `RESET` or a received 0xA5. If the 0xA5 and a new error coincide, the new error wins.

## Timing
- Reset values: `PROGRAMMER_RESET`=0, `PROGRAMMER_InputData`=0x00, `PCK`=0, `SCK`=0, `LINK_ERROR`=0. Receiver and decoder are idle.
- `RESET` mid-byte aborts the frame. The receiver needs a fresh falling edge after release; a partial frame never produces a byte.
- Latency: the stop bit is sampled in cycle S. `rx_valid` is high in S+1. Strobe, data bus, mode change and `LINK_ERROR` update in S+2.
- Strobes are exactly 1 cycle wide.
- Back-to-back bytes with no idle gap are accepted. The next start edge can be seen in RX_IDLE immediately after the stop sample.
- Counters wrap only by explicit reload; the bit counter is `$clog2(CLKS_PER_BIT)` bits wide.

## Test plan
1. `CLKS_PER_BIT`=16: send 0xA5 then 0xC2 → `PROGRAMMER_RESET`=1 at S+2 of byte 1. `PCK` pulses for 1 cycle at S+2 of byte 2 with data=0x02. `SCK` stays 0.
2. In mode: send 0xD0, 0x3C, then 0xD0, 0xA5 → `SCK` pulses twice, with data 0x3C then 0xA5. Mode is unchanged and no `PCK` occurs.
3. Out of mode: send 0xC1 → no `PCK`, `LINK_ERROR`=1. Then send 0xA5 → `LINK_ERROR`=0, `PROGRAMMER_RESET`=1.
4. In mode: send 0xD0, then a byte 0x77 with stop bit=0 → no `SCK`, `LINK_ERROR`=1. Then send 0x5A → `PROGRAMMER_RESET`=0, confirming the decoder returned to DEC_HDR.
5. Hold `RXD` low for 4 cycles, then high → no byte, `LINK_ERROR` stays 0. A following 0xA5 is received correctly.
6. Assert `RESET` halfway through the data bits of 0xC3 while in mode → all outputs return to reset values. After release, a full 0xA5 frame sets `PROGRAMMER_RESET`=1.

Source files
------------

// File: rtl/programmer_link.sv
// rtl/programmer_link.sv - 8N1 serial receiver and framed-protocol decoder driving the programmer inputs
module programmer_link #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RXD,
    output logic       PROGRAMMER_RESET,
    output logic [7:0] PROGRAMMER_InputData,
    output logic       PROGRAMMER_PCK,
    output logic       PROGRAMMER_SCK,
    output logic       LINK_ERROR
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic {
        DEC_HDR,
        DEC_DATA
    } dec_state_t;

    // receiver state
    logic      rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_state_t rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;

    // decoder state
    dec_state_t dec_state_q, dec_state_d;
    logic       mode_q, mode_d;
    logic [7:0] data_q, data_d;
    logic       pck_q, pck_d;
    logic       sck_q, sck_d;
    logic       err_q, err_d;

    // Synchronizer and edge history; reset low so a line held low across reset cannot look like a start edge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rxd_meta_q <= 1'b0;
            rxd_sync_q <= 1'b0;
            rxd_prev_q <= 1'b0;
        end else begin
            rxd_meta_q <= RXD;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // Receiver state register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rx_state_q  <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state_q  <= rx_state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Receiver next state: half-bit delay to centre, then one sample per bit period
    always_comb begin
        rx_state_d  = rx_state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    cnt_d      = HALF_BIT;
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!rxd_sync_q) begin
                        cnt_d      = FULL_BIT;
                        bit_idx_d  = 3'd0;
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    if (rxd_sync_q) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Decoder state and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dec_state_q <= DEC_HDR;
            mode_q      <= 1'b0;
            data_q      <= 8'h00;
            pck_q       <= 1'b0;
            sck_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            dec_state_q <= dec_state_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            pck_q       <= pck_d;
            sck_q       <= sck_d;
            err_q       <= err_d;
        end
    end

    // Decoder next state; framing errors take priority and drop any pending data byte
    always_comb begin
        dec_state_d = dec_state_q;
        mode_d      = mode_q;
        data_d      = data_q;
        pck_d       = 1'b0;
        sck_d       = 1'b0;
        err_d       = err_q;
        if (frame_err_q) begin
            err_d       = 1'b1;
            dec_state_d = DEC_HDR;
        end else if (rx_valid_q) begin
            case (dec_state_q)
                DEC_HDR: begin
                    if (rx_byte_q == 8'hA5) begin
                        mode_d = 1'b1;
                        err_d  = 1'b0;
                    end else if (rx_byte_q == 8'h5A) begin
                        mode_d = 1'b0;
                    end else if (rx_byte_q[7:3] == 5'b11000) begin
                        if (mode_q) begin
                            data_d = {5'b00000, rx_byte_q[2:0]};
                            pck_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (rx_byte_q == 8'hD0) begin
                        if (mode_q) begin
                            dec_state_d = DEC_DATA;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                DEC_DATA: begin
                    data_d      = rx_byte_q;
                    sck_d       = 1'b1;
                    dec_state_d = DEC_HDR;
                end
                default: dec_state_d = DEC_HDR;
            endcase
        end
    end

    assign PROGRAMMER_RESET     = mode_q;
    assign PROGRAMMER_InputData = data_q;
    assign PROGRAMMER_PCK       = pck_q;
    assign PROGRAMMER_SCK       = sck_q;
    assign LINK_ERROR           = err_q;

endmodule

// File: tb/tb_programmer_link.sv
// tb/tb_programmer_link.sv - self-checking bench for programmer_link
module tb_programmer_link;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       RXD;
    logic       PROGRAMMER_RESET;
    logic [7:0] PROGRAMMER_InputData;
    logic       PROGRAMMER_PCK;
    logic       PROGRAMMER_SCK;
    logic       LINK_ERROR;

    programmer_link #(.CLKS_PER_BIT(CPB)) dut (
        .CLK                  (CLK),
        .RESET                (RESET),
        .RXD                  (RXD),
        .PROGRAMMER_RESET     (PROGRAMMER_RESET),
        .PROGRAMMER_InputData (PROGRAMMER_InputData),
        .PROGRAMMER_PCK       (PROGRAMMER_PCK),
        .PROGRAMMER_SCK       (PROGRAMMER_SCK),
        .LINK_ERROR           (LINK_ERROR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_sck;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] b;
        bit         stop;
        bit         mode;
        bit         err;
        logic [7:0] data;
        int         npck;
        int         nsck;
    } vec_t;

    int  cyc = 0;
    int  n_pass = 0;
    int  n_total = 0;
    int  overlap_n = 0;
    int  wide_n = 0;
    int  last_start = 0;
    logic pck_prev = 1'b0;
    logic sck_prev = 1'b0;
    ev_t ev_q[$];
    ev_t exp_q[$];

    bit         m_mode, m_pend, m_err;
    logic [7:0] m_data;

    always @(posedge CLK) cyc <= cyc + 1;

    // observed strobes, sampled on the falling edge
    always @(negedge CLK) begin
        if (PROGRAMMER_PCK && PROGRAMMER_SCK) overlap_n <= overlap_n + 1;
        if ((PROGRAMMER_PCK && pck_prev) || (PROGRAMMER_SCK && sck_prev)) wide_n <= wide_n + 1;
        if (PROGRAMMER_PCK) ev_q.push_back('{is_sck: 1'b0, data: PROGRAMMER_InputData, cyc: cyc});
        if (PROGRAMMER_SCK) ev_q.push_back('{is_sck: 1'b1, data: PROGRAMMER_InputData, cyc: cyc});
        pck_prev <= PROGRAMMER_PCK;
        sck_prev <= PROGRAMMER_SCK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // one 8N1 frame; optionally pulses RESET in the middle of data bit rst_bit
    task automatic send_byte(input logic [7:0] b, input bit stop_val, input int gap, input int rst_bit);
        logic [7:0] bv;
        bv = b;
        last_start = cyc;
        RXD = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RXD = bv[i];
            if (i == rst_bit) begin
                repeat (CPB / 2) @(negedge CLK);
                RESET = 1'b1;
                repeat (4) @(negedge CLK);
                RESET = 1'b0;
                repeat (CPB / 2 - 4) @(negedge CLK);
            end else begin
                repeat (CPB) @(negedge CLK);
            end
        end
        RXD = stop_val;
        repeat (CPB) @(negedge CLK);
        RXD = 1'b1;
        repeat (gap) @(negedge CLK);
    endtask

    task automatic model_reset();
        m_mode = 1'b0;
        m_pend = 1'b0;
        m_err  = 1'b0;
        m_data = 8'h00;
        exp_q.delete();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        model_reset();
        ev_q.delete();
    endtask

    // protocol-level reference: one received byte (or framing error) at a time
    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err  = 1'b1;
            m_pend = 1'b0;
        end else if (m_pend) begin
            m_data = b;
            m_pend = 1'b0;
            exp_q.push_back('{is_sck: 1'b1, data: b, cyc: 0});
        end else if (b == 8'hA5) begin
            m_mode = 1'b1;
            m_err  = 1'b0;
        end else if (b == 8'h5A) begin
            m_mode = 1'b0;
        end else if (b >= 8'hC0 && b <= 8'hC7) begin
            if (m_mode) begin
                m_data = b - 8'hC0;
                exp_q.push_back('{is_sck: 1'b0, data: m_data, cyc: 0});
            end else begin
                m_err = 1'b1;
            end
        end else if (b == 8'hD0) begin
            if (m_mode) m_pend = 1'b1;
            else m_err = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    vec_t vt[17];

    initial begin
        int npck, nsck, d, n, r, gap;
        logic [7:0] b;
        bit ok;

        vt[0]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 0, 0};
        vt[1]  = '{8'hC2, 1'b1, 1'b1, 1'b0, 8'h02, 1, 0};
        vt[2]  = '{8'hD0, 1'b1, 1'b1, 1'b0, 8'h02, 0, 0};
        vt[3]  = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 1};
        vt[4]  = '{8'hD0, 1'b1, 1'b1, 1'b0, 8'h3C, 0, 0};
        vt[5]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 1};
        vt[6]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 8'hA5, 0, 0};
        vt[7]  = '{8'hC1, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
        vt[8]  = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 0};
        vt[9]  = '{8'hD0, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 0};
        vt[10] = '{8'h77, 1'b0, 1'b1, 1'b1, 8'hA5, 0, 0};
        vt[11] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
        vt[12] = '{8'hD0, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
        vt[13] = '{8'h33, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 0};
        vt[14] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5, 0, 0};
        vt[15] = '{8'hC7, 1'b1, 1'b1, 1'b0, 8'h07, 1, 0};
        vt[16] = '{8'h42, 1'b1, 1'b1, 1'b1, 8'h07, 0, 0};

        RXD   = 1'b1;
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        chk("reset mode", 32'(PROGRAMMER_RESET), 0);
        chk("reset data", 32'(PROGRAMMER_InputData), 0);
        chk("reset pck", 32'(PROGRAMMER_PCK), 0);
        chk("reset sck", 32'(PROGRAMMER_SCK), 0);
        chk("reset err", 32'(LINK_ERROR), 0);
        RESET = 1'b0;
        repeat (4) @(negedge CLK);

        // table: good frames back-to-back, bad-stop frames followed by a short idle gap
        for (int i = 0; i < 17; i++) begin
            ev_q.delete();
            send_byte(vt[i].b, vt[i].stop, vt[i].stop ? 0 : 4, -1);
            npck = 0;
            nsck = 0;
            foreach (ev_q[k]) begin
                if (ev_q[k].is_sck) nsck++;
                else npck++;
                d = ev_q[k].cyc - last_start;
                chk($sformatf("v%0d latency", i),
                    32'((d >= 9 * CPB + CPB / 2) && (d < 10 * CPB)), 1);
            end
            chk($sformatf("v%0d mode", i), 32'(PROGRAMMER_RESET), 32'(vt[i].mode));
            chk($sformatf("v%0d err", i), 32'(LINK_ERROR), 32'(vt[i].err));
            chk($sformatf("v%0d data", i), 32'(PROGRAMMER_InputData), 32'(vt[i].data));
            chk($sformatf("v%0d npck", i), 32'(npck), 32'(vt[i].npck));
            chk($sformatf("v%0d nsck", i), 32'(nsck), 32'(vt[i].nsck));
        end

        // short low glitch on an idle line
        do_reset();
        RXD = 1'b0;
        repeat (4) @(negedge CLK);
        RXD = 1'b1;
        repeat (40) @(negedge CLK);
        chk("glitch events", 32'(ev_q.size()), 0);
        chk("glitch err", 32'(LINK_ERROR), 0);
        chk("glitch mode", 32'(PROGRAMMER_RESET), 0);
        send_byte(8'hA5, 1'b1, 2, -1);
        chk("post-glitch mode", 32'(PROGRAMMER_RESET), 1);
        chk("post-glitch err", 32'(LINK_ERROR), 0);

        // RESET halfway through the data bits of a command frame
        ev_q.delete();
        send_byte(8'hC3, 1'b1, 20, 4);
        chk("midrst mode", 32'(PROGRAMMER_RESET), 0);
        chk("midrst data", 32'(PROGRAMMER_InputData), 0);
        chk("midrst pck", 32'(PROGRAMMER_PCK), 0);
        chk("midrst sck", 32'(PROGRAMMER_SCK), 0);
        chk("midrst err", 32'(LINK_ERROR), 0);
        chk("midrst events", 32'(ev_q.size()), 0);
        send_byte(8'hA5, 1'b1, 2, -1);
        chk("post-midrst mode", 32'(PROGRAMMER_RESET), 1);

        // randomized protocol traffic against the reference model
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            if (i == 0 || r == 0) b = 8'hA5;
            else if (r == 1) b = 8'h5A;
            else if (r <= 3) b = 8'hD0;
            else if (r <= 5) b = 8'hC0 + 8'($urandom_range(0, 7));
            else b = 8'($urandom);
            ok  = (i == 0) || ($urandom_range(0, 9) != 0);
            gap = ok ? $urandom_range(0, 2) : 3 + $urandom_range(0, 2);
            ev_q.delete();
            send_byte(b, ok, gap, -1);
            model_byte(b, ok);
            chk($sformatf("r%0d mode", i), 32'(PROGRAMMER_RESET), 32'(m_mode));
            chk($sformatf("r%0d err", i), 32'(LINK_ERROR), 32'(m_err));
            chk($sformatf("r%0d data", i), 32'(PROGRAMMER_InputData), 32'(m_data));
            chk($sformatf("r%0d nev", i), 32'(ev_q.size()), 32'(exp_q.size()));
            n = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
            for (int k = 0; k < n; k++) begin
                chk($sformatf("r%0d ev%0d", i, k), {23'd0, ev_q[k].is_sck, ev_q[k].data},
                    {23'd0, exp_q[k].is_sck, exp_q[k].data});
            end
            exp_q.delete();
        end

        repeat (4) @(negedge CLK);
        chk("pck/sck overlap", 32'(overlap_n), 0);
        chk("strobe width", 32'(wide_n), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
